// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: FSM states, opcodes,
// data width and the latched command record.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OPC_NEG    = 3'b000; // ~A + 1
    localparam logic [2:0] OPC_INC    = 3'b001; // A + 1
    localparam logic [2:0] OPC_ADD    = 3'b010; // A + B + C
    localparam logic [2:0] OPC_ADDSHR = 3'b011; // A + (B >> 1)
    localparam logic [2:0] OPC_AND    = 3'b100; // A & B
    localparam logic [2:0] OPC_OR     = 3'b101; // A | B
    localparam logic [2:0] OPC_CAT    = 3'b110; // {A[7:0], B[7:0]}
    localparam logic [2:0] OPC_ZERO   = 3'b111; // 0

    typedef struct packed {
        logic [2:0]        opc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              c;
    } cmd_t;

endpackage

// File: rtl/alu_arbiter_alu16_core.sv
// Purely combinational 16-bit ALU; all arithmetic wraps modulo 2^16.
module alu16_core
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c,
    input  logic [2:0]        opc,
    output logic [DATA_W-1:0] w
);

    // Opcode decode; sums are sized to DATA_W so the carry-out is dropped.
    always_comb begin
        // NOTE: w gets a default before the case so no path leaves it unassigned, which would infer a latch.
        w = '0;
        case (opc)
            OPC_NEG:    w = ~a + 16'd1;
            OPC_INC:    w = a + 16'd1;
            OPC_ADD:    w = a + b + {{(DATA_W-1){1'b0}}, c};
            OPC_ADDSHR: w = a + (b >> 1);
            OPC_AND:    w = a & b;
            OPC_OR:     w = a | b;
            OPC_CAT:    w = {a[7:0], b[7:0]};
            default:    w = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle ALU with a
// registered, flow-controlled response.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2:0]        req_opc0,
    input  logic [2:0]        req_opc1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic              req_c0,
    input  logic              req_c1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_w,
    output logic              rsp_zer,
    output logic              rsp_neg,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              last_grant;   // also identifies the port being served
    logic              grant_en;
    logic              grant_port;
    cmd_t              cmd_q, cmd_sel;
    logic [DATA_W-1:0] alu_w;

    // Round-robin pick: under contention the port that did not win last time.
    always_comb begin
        grant_port = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_port = ~last_grant;
        end
        cmd_sel = grant_port ? cmd_t'{req_opc1, req_a1, req_b1, req_c1}
                             : cmd_t'{req_opc0, req_a0, req_b0, req_c0};
    end

    // Next-state logic; a grant is only offered from IDLE.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    grant_en  = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready[last_grant]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs; reset masks req_ready so it drops immediately.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (grant_en && !rst) begin
            req_ready[grant_port] = 1'b1;
        end
        if (state == ST_RESP) begin
            rsp_valid[last_grant] = 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping and operand capture, only when a command is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand registers are cleared on reset too, so a discarded command leaves no stale data behind.
            last_grant <= 1'b1;
            cmd_q      <= '0;
        end else if (grant_en) begin
            last_grant <= grant_port;
            cmd_q      <= cmd_sel;
        end
    end

    alu16_core u_alu (
        .a   (cmd_q.a),
        .b   (cmd_q.b),
        .c   (cmd_q.c),
        .opc (cmd_q.opc),
        .w   (alu_w)
    );

    // Result and flag registers, loaded in the single EXEC cycle and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_w   <= '0;
            rsp_zer <= 1'b0;
            rsp_neg <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_w   <= alu_w;
            rsp_zer <= (alu_w == '0);
            rsp_neg <= alu_w[DATA_W-1];
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 req_valid[1:0]  input  2  per-requester command valid (index 0 = port 0, index 1 = port 1).
REQ-004 req_ready[1:0]  output  2  per-requester command accepted this cycle (one-hot or zero).
REQ-005 req_opc0, req_opc1  input  3 each  ALU opcode per port.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  16 each  operands per port.
REQ-007 req_c0, req_c1  input  1 each  carry-in per port.
REQ-008 rsp_valid[1:0]  output  2  result valid for the corresponding port.
REQ-009 rsp_ready[1:0]  input  2  per-port result consumed.
REQ-010 rsp_w  output  16  registered result; rsp_zer, rsp_neg  output  1 each  registered flags.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States: IDLE, EXEC, RESP; encoding in shared package.
REQ-013 IDLE: if any req_valid, grant one port, assert its req_ready in that same cycle (combinational from state/valid/priority), latch opc/a/b/c into operand registers, go EXEC.
REQ-014 Arbitration round-robin: last_grant register; when both valid, grant the port not equal to last_grant; single valid always granted.
REQ-015 last_grant updates only on a grant; reset value 1, so port 0 wins the first contention.
REQ-016 EXEC (exactly one cycle): drive latched operands into ALU, register result into rsp_w, rsp_zer = (result == 0), rsp_neg = result[15], go RESP.
REQ-017 RESP: assert rsp_valid for the granted port only; hold rsp_w/flags stable until that port's rsp_ready high; on handshake return to IDLE.
REQ-018 rsp_ready of the non-granted port is ignored; req_ready is 0 in EXEC and RESP.
REQ-019 Latency: accept at cycle N, rsp_valid at N+2; min issue interval 3 cycles (next accept earliest cycle after response handshake).
REQ-020 ALU opcode table (16-bit, wraps modulo 2^16): 000 ~A+1; 001 A+1; 010 A+B+C; 011 A+(B>>1) logical; 100 A&B; 101 A|B; 110 {A[7:0],B[7:0]}; 111 result 0.
REQ-021 Operand registers capture only on grant; requester inputs changing after acceptance do not affect result.

Reset
REQ-022 On rst high, immediately: state IDLE, req_ready 0, rsp_valid 0, rsp_w 0, rsp_zer 0, rsp_neg 0, busy 0, last_grant 1, operand registers 0.
REQ-023 Reset mid-operation (EXEC or RESP) discards the command; no response emitted after reset release.
REQ-024 First grant possible on the first rising edge after rst deasserts.

Structure
REQ-025 Shared package holds: state enum, opcode constants (OPC_NEG..OPC_ZERO), data width parameter (16).
REQ-026 One sub-module alu16_core: purely combinational, inputs a, b, c, opc, outputs w, implementing REQ-020; flags computed in alu_arbiter.

Verification
REQ-027 Single request port 0, opc 010, A=0x0003, B=0x0004, C=1 -> req_ready[0] same cycle, rsp_valid[0] 2 cycles later, rsp_w 0x0008, zer 0, neg 0.
REQ-028 Both ports valid continuously, rsp_ready tied 1 -> grants alternate 0,1,0,1; port 1 opc 000 A=0x0001 -> rsp_w 0xFFFF, neg 1.
REQ-029 Port 0 opc 001 A=0xFFFF -> rsp_w 0x0000, zer 1 (wrap-around).
REQ-030 Hold rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_w stable, req_ready 0 throughout; port 1 asserting rsp_ready has no effect.
REQ-031 Assert rst during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, next contention granted to port 0.
REQ-032 Opc 110 A=0x12AB, B=0x34CD -> 0xABCD; opc 011 A=0x0010, B=0x0021 -> 0x0020; opc 111 -> 0x0000, zer 1.
